// File: rtl/n64_flashram_ctrl_if.sv
// PI-side request/acknowledge bus between the N64 bus arbiter (master)
// and n64_flashram_ctrl (slave).
interface n64_flashram_ctrl_if;
    logic        bus_request;
    logic        bus_write;
    logic [16:0] bus_address;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_request, bus_write, bus_address, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/n64_flashram_ctrl.sv
// N64 FlashRAM front end: PI command/status decode, page write buffer and backend job handshake.
// Optional macro FLASHRAM_STATUS_CLEAR_EN: STATUS-mode data writes reload the DONE bits.
module n64_flashram_ctrl #(
    parameter int unsigned BUFFER_WORDS    = 32,
    parameter int unsigned SECTOR_BITS     = 10,
    parameter logic [31:0] TYPE_ID         = 32'h1111_8001,
    parameter logic [31:0] MODEL_ID        = 32'h00C2_001D,
    parameter int unsigned MIN_BUSY_CYCLES = 0,
    localparam int unsigned AW             = $clog2(BUFFER_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    n64_flashram_ctrl_if.slave     bus,
    output logic                   read_mode,
    output logic                   op_pending,
    output logic                   op_write_or_erase,
    output logic [SECTOR_BITS-1:0] op_sector,
    output logic                   op_sector_or_all,
    input  logic                   op_done,
    input  logic [AW-1:0]          buf_raddr,
    output logic [31:0]            buf_rdata
);

    typedef enum logic {BUS_IDLE, BUS_WAIT} bus_state_t;
    typedef enum logic [1:0] {MODE_STATUS, MODE_ID, MODE_READ, MODE_BUFFER} mode_t;

    localparam logic [7:0] OP_STATUS      = 8'hD2;
    localparam logic [7:0] OP_ID          = 8'hE1;
    localparam logic [7:0] OP_READ        = 8'hF0;
    localparam logic [7:0] OP_BUFFER      = 8'hB4;
    localparam logic [7:0] OP_ERASE_SECT  = 8'h4B;
    localparam logic [7:0] OP_ERASE_CHIP  = 8'h3C;
    localparam logic [7:0] OP_ERASE_GO    = 8'h78;
    localparam logic [7:0] OP_PROGRAM     = 8'hA5;

    // Counter is one value wider than needed so it can saturate above the minimum.
    localparam int unsigned CW      = $clog2(MIN_BUSY_CYCLES + 2);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_BUSY_CYCLES);

    bus_state_t bus_state, bus_state_next;
    mode_t      mode;
    logic       accept;
    logic [3:0] status;
    logic       erase_armed;
    logic [7:0] opcode;
    logic [15:0] hi_half;
    logic       done_seen;
    logic [CW-1:0] busy_cnt;
    logic [15:0] rdata_q;
    logic [15:0] rd_value;
    logic       active;
    logic       wr_ok, cmd_wr, data_wr, buf_hi_wr, buf_lo_wr;
    logic [SECTOR_BITS-1:0] sector_in;
    logic [31:0] mem [BUFFER_WORDS];
    logic       unused_addr0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus_state <= BUS_IDLE;
        else          bus_state <= bus_state_next;
    end

    always_comb begin
        bus_state_next = bus_state;
        accept         = 1'b0;
        bus.bus_ack    = 1'b0;
        unique case (bus_state)
            BUS_IDLE: if (bus.bus_request) begin
                accept         = 1'b1;
                bus_state_next = BUS_WAIT;
            end
            BUS_WAIT: begin
                bus.bus_ack    = 1'b1;
                bus_state_next = BUS_IDLE;
            end
        endcase
    end

    // ID words only appear at data-window offsets 0..7; everything else reads 0 in ID mode.
    always_comb begin
        rd_value = '0;
        if (mode == MODE_ID) begin
            if (!bus.bus_address[16] && bus.bus_address[15:3] == '0) begin
                unique case (bus.bus_address[2:1])
                    2'd0: rd_value = TYPE_ID[31:16];
                    2'd1: rd_value = TYPE_ID[15:0];
                    2'd2: rd_value = MODEL_ID[31:16];
                    2'd3: rd_value = MODEL_ID[15:0];
                endcase
            end
        end else if (bus.bus_address[1]) begin
            rd_value = {12'd0, status};
        end
    end

    assign bus.bus_rdata = bus.bus_ack ? rdata_q : '0;
    assign read_mode     = (mode == MODE_READ);
    assign active        = op_pending | status[0] | status[1];
    assign wr_ok         = accept & bus.bus_write & ~active;
    assign cmd_wr        = wr_ok & bus.bus_address[16];
    assign data_wr       = wr_ok & ~bus.bus_address[16];
    assign buf_hi_wr     = data_wr & (mode == MODE_BUFFER) & ~bus.bus_address[1];
    assign buf_lo_wr     = data_wr & (mode == MODE_BUFFER) & bus.bus_address[1];
    assign sector_in     = bus.bus_wdata[SECTOR_BITS-1:0];
    assign unused_addr0  = bus.bus_address[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode              <= MODE_STATUS;
            status            <= 4'b0000;
            erase_armed       <= 1'b0;
            opcode            <= '0;
            hi_half           <= '0;
            done_seen         <= 1'b0;
            busy_cnt          <= '0;
            rdata_q           <= '0;
            op_pending        <= 1'b0;
            op_write_or_erase <= 1'b0;
            op_sector         <= '0;
            op_sector_or_all  <= 1'b0;
        end else begin
            if (accept) rdata_q <= bus.bus_write ? '0 : rd_value;
            if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;

            if (op_done && op_pending) begin
                op_pending <= 1'b0;
                done_seen  <= 1'b1;
            end
            if (done_seen && busy_cnt >= MIN_CNT) begin
                done_seen   <= 1'b0;
                status[1:0] <= 2'b00;
                if (op_write_or_erase) status[3] <= 1'b1;
                else                   status[2] <= 1'b1;
            end

            if (buf_hi_wr) hi_half <= bus.bus_wdata;
`ifdef FLASHRAM_STATUS_CLEAR_EN
            if (data_wr && mode == MODE_STATUS && bus.bus_address[1])
                status[3:2] <= bus.bus_wdata[3:2];
`endif
            if (cmd_wr && !bus.bus_address[1]) opcode <= bus.bus_wdata[15:8];

            if (cmd_wr && bus.bus_address[1]) begin
                erase_armed <= 1'b0;
                case (opcode)
                    OP_STATUS: mode <= MODE_STATUS;
                    OP_ID:     mode <= MODE_ID;
                    OP_READ:   mode <= MODE_READ;
                    OP_BUFFER: mode <= MODE_BUFFER;
                    OP_ERASE_SECT: begin
                        mode             <= MODE_STATUS;
                        erase_armed      <= 1'b1;
                        op_sector        <= sector_in;
                        op_sector_or_all <= 1'b0;
                    end
                    OP_ERASE_CHIP: begin
                        mode             <= MODE_STATUS;
                        erase_armed      <= 1'b1;
                        op_sector        <= '0;
                        op_sector_or_all <= 1'b1;
                    end
                    OP_ERASE_GO: begin
                        mode <= MODE_STATUS;
                        if (erase_armed) begin
                            op_pending        <= 1'b1;
                            op_write_or_erase <= 1'b1;
                            status[1]         <= 1'b1;
                            status[3]         <= 1'b0;
                            busy_cnt          <= '0;
                            done_seen         <= 1'b0;
                        end
                    end
                    OP_PROGRAM: begin
                        mode              <= MODE_STATUS;
                        op_sector         <= sector_in;
                        op_sector_or_all  <= 1'b0;
                        op_pending        <= 1'b1;
                        op_write_or_erase <= 1'b0;
                        status[0]         <= 1'b1;
                        status[2]         <= 1'b0;
                        busy_cnt          <= '0;
                        done_seen         <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_lo_wr) mem[bus.bus_address[AW+1:2]] <= {hi_half, bus.bus_wdata};
        buf_rdata <= mem[buf_raddr];
    end

endmodule

// File: tb/tb_n64_flashram_ctrl.sv
// Randomised self-checking bench for n64_flashram_ctrl with a cycle-level reference model.
module tb_n64_flashram_ctrl;
    localparam int unsigned BW   = 32;
    localparam int unsigned AW   = $clog2(BW);
    localparam int unsigned SB   = 10;
    localparam int unsigned MINB = 100;
    localparam logic [31:0] TID  = 32'h1111_8001;
    localparam logic [31:0] MID  = 32'h00C2_001D;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          op_done;
    logic [AW-1:0] buf_raddr;
    logic          read_mode, op_pending, op_write_or_erase, op_sector_or_all;
    logic [SB-1:0] op_sector;
    logic [31:0]   buf_rdata;

    n64_flashram_ctrl_if bus();

    n64_flashram_ctrl #(
        .BUFFER_WORDS(BW), .SECTOR_BITS(SB), .TYPE_ID(TID),
        .MODEL_ID(MID), .MIN_BUSY_CYCLES(MINB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .read_mode(read_mode), .op_pending(op_pending),
        .op_write_or_erase(op_write_or_erase), .op_sector(op_sector),
        .op_sector_or_all(op_sector_or_all), .op_done(op_done),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode;      // 0 status, 1 id, 2 read, 3 buffer
    logic [3:0]  m_status;
    bit          m_armed, m_all, m_we, m_pending, m_job, m_ack, m_buf_ok;
    logic [7:0]  m_op;
    logic [15:0] m_hi, m_rdata;
    logic [SB-1:0] m_sector;
    logic [31:0] m_mem [BW];
    bit          m_val [BW];
    logic [31:0] m_buf;
    longint      cyc, start_at, done_at;

    function automatic logic [15:0] read_value(input logic [16:0] a);
        logic [31:0] w;
        if (m_mode == 1) begin
            if (!a[16] && a[15:3] == 13'd0) begin
                w = a[2] ? MID : TID;
                return a[1] ? w[15:0] : w[31:16];
            end
            return 16'h0;
        end
        return a[1] ? {12'd0, m_status} : 16'h0;
    endfunction

    task automatic start_job(input bit erase);
        m_pending = 1; m_job = 1; m_we = erase;
        start_at = cyc; done_at = -1;
        if (erase) begin m_status[1] = 1'b1; m_status[3] = 1'b0; end
        else       begin m_status[0] = 1'b1; m_status[2] = 1'b0; end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_status = 4'h0; m_armed = 0; m_all = 0; m_we = 0;
            m_pending = 0; m_job = 0; m_ack = 0; m_rdata = 16'h0; m_sector = '0;
            m_op = 8'h00; m_hi = 16'h0; m_buf_ok = 0; m_buf = 32'h0;
            cyc = 0; start_at = 0; done_at = -1;
            for (int i = 0; i < BW; i++) m_val[i] = 0;
        end else begin : step
            bit active, acc, prev;
            logic [16:0] a;
            logic [15:0] d;
            a = bus.bus_address;
            d = bus.bus_wdata;
            active = m_pending || m_job;
            acc = bus.bus_request && !m_ack;
            m_buf_ok = m_val[buf_raddr];
            m_buf = m_mem[buf_raddr];
            if (acc) m_rdata = bus.bus_write ? 16'h0 : read_value(a);
            if (op_done && m_pending) begin m_pending = 0; done_at = cyc; end
            if (m_job && done_at >= 0 && cyc >= done_at + 1 && cyc >= start_at + 1 + MINB) begin
                m_job = 0;
                m_status[1:0] = 2'b00;
                if (m_we) m_status[3] = 1'b1; else m_status[2] = 1'b1;
            end
            if (acc && bus.bus_write && !active) begin
                if (a[16]) begin
                    if (!a[1]) m_op = d[15:8];
                    else begin
                        prev = m_armed; m_armed = 0;
                        case (m_op)
                            8'hD2: m_mode = 0;
                            8'hE1: m_mode = 1;
                            8'hF0: m_mode = 2;
                            8'hB4: m_mode = 3;
                            8'h4B: begin m_mode = 0; m_armed = 1; m_sector = d[SB-1:0]; m_all = 0; end
                            8'h3C: begin m_mode = 0; m_armed = 1; m_sector = '0; m_all = 1; end
                            8'h78: begin m_mode = 0; if (prev) start_job(1'b1); end
                            8'hA5: begin m_mode = 0; m_sector = d[SB-1:0]; m_all = 0; start_job(1'b0); end
                            default: ;
                        endcase
                    end
                end else if (m_mode == 3) begin
                    if (!a[1]) m_hi = d;
                    else begin m_mem[a[AW+1:2]] = {m_hi, d}; m_val[a[AW+1:2]] = 1; end
                end
`ifdef FLASHRAM_STATUS_CLEAR_EN
                else if (m_mode == 0 && a[1]) m_status[3:2] = d[3:2];
`endif
            end
            m_ack = acc;
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("bus_ack", bus.bus_ack, m_ack);
        check("bus_rdata", bus.bus_rdata, m_ack ? m_rdata : 16'h0);
        check("read_mode", read_mode, m_mode == 2);
        check("op_pending", op_pending, m_pending);
        check("op_write_or_erase", op_write_or_erase, m_we);
        check("op_sector", op_sector, m_sector);
        check("op_sector_or_all", op_sector_or_all, m_all);
        if (m_buf_ok) check("buf_rdata", buf_rdata, m_buf);
    end

    // ---------------- background drivers ----------------
    bit          auto_mode = 0;
    bit          man_done  = 0;
    logic [AW-1:0] man_raddr = '0;

    always @(posedge clk) begin
        #1;
        if (auto_mode) begin
            buf_raddr = AW'($urandom_range(0, BW - 1));
            op_done = (m_pending && $urandom_range(0, 7) == 0) || ($urandom_range(0, 40) == 0);
        end else begin
            buf_raddr = man_raddr;
            op_done = man_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic xfer(input bit wr, input logic [16:0] a, input logic [15:0] d, output logic [15:0] rd);
        bus.bus_request = 1'b1; bus.bus_write = wr; bus.bus_address = a; bus.bus_wdata = d;
        tick();
        bus.bus_request = 1'b0; bus.bus_write = 1'b0;
        #2 rd = bus.bus_rdata;
        tick();
    endtask

    task automatic cmd(input logic [7:0] op, input logic [15:0] d);
        logic [15:0] rd;
        xfer(1'b1, 17'h10000, {op, 8'h00}, rd);
        xfer(1'b1, 17'h10002, d, rd);
    endtask

    task automatic read_status(output logic [15:0] rd);
        xfer(1'b0, 17'h00002, 16'h0, rd);
    endtask

    task automatic pulse_done();
        man_done = 1'b1; tick(); man_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick(2); reset_n = 1'b1; tick();
    endtask

    logic [15:0] rd;
    logic [15:0] id_exp [4] = '{16'h1111, 16'h8001, 16'h00C2, 16'h001D};
    logic [7:0]  ops [9]    = '{8'hD2, 8'hE1, 8'hF0, 8'hB4, 8'h4B, 8'h3C, 8'h78, 8'hA5, 8'h00};

    initial begin
        bus.bus_request = 1'b0; bus.bus_write = 1'b0;
        bus.bus_address = '0; bus.bus_wdata = '0;
        op_done = 1'b0; buf_raddr = '0;
        #1 reset_n = 1'b0;
        tick(3);
        check("rst_op_pending", op_pending, 1'b0);
        check("rst_op_sector", op_sector, '0);
        check("rst_bus_ack", bus.bus_ack, 1'b0);
        check("rst_read_mode", read_mode, 1'b0);
        reset_n = 1'b1;
        tick();
        read_status(rd);
        check("rst_status", rd, 16'h0000);

        cmd(8'hE1, 16'h0);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 17'(i * 2), 16'h0, rd);
            check("id_word", rd, id_exp[i]);
        end
        check("id_read_mode", read_mode, 1'b0);

        cmd(8'hB4, 16'h0);
        for (int n = 0; n < 32; n++) begin
            xfer(1'b1, 17'(n * 4), 16'hA5A5, rd);
            xfer(1'b1, 17'(n * 4 + 2), 16'(n), rd);
        end
        man_raddr = AW'(5);
        tick(2);
        check("buf_word5", buf_rdata, 32'hA5A5_0005);

        cmd(8'hA5, 16'h0123);
        check("prog_pending", op_pending, 1'b1);
        check("prog_sector", op_sector, 10'h123);
        check("prog_kind", op_write_or_erase, 1'b0);
        read_status(rd);
        check("prog_busy_status", rd, 16'h0001);
        pulse_done();
        begin : wait_prog
            bit seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                read_status(rd);
                if (rd[2]) seen = 1;
            end
        end
        check("prog_done_status", rd, 16'h0004);
        check("prog_pending_clr", op_pending, 1'b0);

        cmd(8'h78, 16'h0);
        check("unarmed_erase", op_pending, 1'b0);

        do_reset();
        cmd(8'h3C, 16'h0);
        cmd(8'h78, 16'h0);
        check("chip_erase_all", op_sector_or_all, 1'b1);
        check("chip_erase_pending", op_pending, 1'b1);
        tick(8);
        pulse_done();
        cmd(8'hF0, 16'h0);
        tick(70);
        read_status(rd);
        check("erase_min_busy", rd, 16'h0002);
        tick(20);
        read_status(rd);
        check("erase_done_status", rd, 16'h0008);
        check("f0_ignored", read_mode, 1'b0);

        xfer(1'b1, 17'h00002, 16'h0000, rd);
        read_status(rd);
`ifdef FLASHRAM_STATUS_CLEAR_EN
        check("status_clear", rd, 16'h0000);
`else
        check("status_clear", rd, 16'h0008);
`endif

        auto_mode = 1;
        for (int t = 0; t < 300; t++) begin
            int r;
            logic [7:0] op;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    op = ops[$urandom_range(0, 8)];
                    if (op == 8'h00) op = 8'($urandom);
                    cmd(op, 16'($urandom));
                end
                3: xfer(1'b1, {1'b0, 16'($urandom)}, 16'($urandom), rd);
                4, 5, 6: xfer(1'b0, 17'($urandom), 16'h0, rd);
                7: read_status(rd);
                8: for (int k = 0; k < 3; k++) begin
                    int w;
                    w = $urandom_range(0, BW - 1);
                    xfer(1'b1, 17'(w * 4), 16'($urandom), rd);
                    xfer(1'b1, 17'(w * 4 + 2), 16'($urandom), rd);
                end
                default: tick($urandom_range(1, 20));
            endcase
        end

        auto_mode = 0;
        tick(2);
        do_reset();
        cmd(8'hA5, 16'h0055);
        check("midjob_pending", op_pending, 1'b1);
        #1 reset_n = 1'b0;
        #1 check("async_rst_pending", op_pending, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        read_status(rd);
        check("async_rst_status", rd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/n64_flashram_ctrl.md
Name: n64_flashram_ctrl

Overview:
- Parametrised next-generation N64 FlashRAM emulation front end.
- Decodes PI-side 16-bit bus accesses into the FlashRAM command and status protocol, and holds the page write buffer.
- Issues erase/program jobs to the SDRAM-side backend over a pending/done handshake.
- Generalises buffer depth, sector width and ID words, and adds an enforced minimum busy time per job. Sits between the N64 bus arbiter and the flashram backend.

Parameters:
- BUFFER_WORDS, 32, 32-bit words in the write buffer; power of two, 8..128; AW = clog2(BUFFER_WORDS).
- SECTOR_BITS, 10, width of sector/page number taken from command wdata.
- TYPE_ID, 32'h1111_8001, first ID word returned in ID mode.
- MODEL_ID, 32'h00C2_001D, second ID word returned in ID mode.
- MIN_BUSY_CYCLES, 0, minimum clocks the busy status bit stays set after a job is issued; 0 disables the minimum.

Ports:
- clk  in  1  system clock; all logic is on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus_request  in  1  access strobe, one cycle.
- bus_write  in  1  1 = write.
- bus_address  in  17  [16] 1 = command register, 0 = buffer/data window; [1] selects low/high halfword.
- bus_wdata  in  16  write data.
- bus_rdata  out  16  read data, valid while bus_ack.
- bus_ack  out  1  one-cycle acknowledge.
- read_mode  out  1  high while in READ state (SDRAM serves data window).
- op_pending  out  1  job request to backend.
- op_write_or_erase  out  1  0 = program page, 1 = erase.
- op_sector  out  SECTOR_BITS  target sector/page.
- op_sector_or_all  out  1  1 = whole-chip erase.
- op_done  in  1  one-cycle job completion pulse from backend.
- buf_raddr  in  AW  backend buffer read address.
- buf_rdata  out  32  buffer word; registered, 1-cycle latency.

Behaviour:
- Reset values:
  - bus_ack = 0, op_pending = 0, mode = STATUS, status = 4'b0000, erase_armed = 0.
  - op_sector = 0, op_write_or_erase = 0, op_sector_or_all = 0, busy counter = 0.
  - Buffer contents undefined.
- Bus FSM IDLE/WAIT:
  - In IDLE, bus_request is accepted: bus_ack = 1 on the next cycle, then WAIT for one cycle, then IDLE.
  - bus_request during WAIT is ignored. The master must not issue back-to-back requests.
- bus_rdata is 0 unless bus_ack.
  - In ID mode: address[2:1] = 0..3 returns TYPE_ID[31:16], TYPE_ID[15:0], MODEL_ID[31:16], MODEL_ID[15:0]. Other addresses do not alias into ID mode.
  - Otherwise: address[1] = 1 returns {12'd0, status}; address[1] = 0 returns 0.
- Status bits: [0] WRITE_BUSY, [1] ERASE_BUSY, [2] WRITE_DONE, [3] ERASE_DONE.
- Command register: write with address[16] = 1.
  - address[1] = 0 latches opcode = wdata[15:8].
  - address[1] = 1 executes the latched opcode and clears erase_armed unless the opcode re-arms it:
    - D2: mode = STATUS.
    - E1: mode = ID.
    - F0: mode = READ.
    - B4: mode = BUFFER.
    - 4B: mode = STATUS, erase_armed = 1, op_sector = wdata[SECTOR_BITS-1:0], all = 0.
    - 3C: mode = STATUS, erase_armed = 1, op_sector = 0, all = 1.
    - 78: mode = STATUS; if erase_armed, start erase job.
    - A5: mode = STATUS; start program job, op_sector = wdata[SECTOR_BITS-1:0], all = 0.
    - Unknown opcode: no change except erase_armed = 0.
- Job start:
  - Sets the matching BUSY bit and clears the matching DONE bit.
  - op_pending = 1; busy counter loads 0.
- Completion:
  - op_done clears op_pending on the next edge and records done_seen.
  - The BUSY bit clears and the DONE bit sets on the first cycle where done_seen and counter >= MIN_BUSY_CYCLES. The counter saturates.
  - op_done while no job is pending is ignored.
- Active job = op_pending or BUSY still set. During an active job, all bus writes are acked and have no effect. Reads always work.
- Buffer writes: only when address[16] = 0, write, and mode = BUFFER.
  - address[1] = 0 latches the high halfword.
  - address[1] = 1 writes {high, wdata} to word address[AW+1:2]. Higher address bits wrap.
- Simultaneous op_done and an accepted bus write in the same cycle: completion is applied first; the write is evaluated against pre-edge state, so it is still dropped.
- Reset asserted mid-job: immediately drops op_pending and clears status. The backend must abort.

Optional Feature:
- FLASHRAM_STATUS_CLEAR_EN defined: a data-window write with address[1] = 1 in STATUS mode, with no job active, loads DONE bits [2] and [3] from wdata[2] and wdata[3]. BUSY bits are unaffected.
- Undefined: such writes are acked and ignored.

Test Plan:
- E1 command, then read 0x0,0x2,0x4,0x6 of the data window -> 0x1111, 0x8001, 0x00C2, 0x001D; read_mode = 0.
- B4, write 32 words (word n = 0xA5A50000+n), set buf_raddr = 5 -> buf_rdata = 0xA5A50005 one cycle later.
- A5 with wdata = 0x0123 -> op_pending = 1, op_sector = 0x123, op_write_or_erase = 0, status reads 0x1. After op_done -> status 0x4, op_pending = 0.
- 78 without a prior 4B/3C -> no op_pending. 3C then 78 -> op_sector_or_all = 1, status 0x2. With MIN_BUSY_CYCLES = 100 and op_done at cycle 10 -> status 0x2 until cycle 100, then 0x8.
- F0 command issued while a job is active -> ignored, mode unchanged. Assert reset_n low mid-job -> op_pending = 0 and status = 0 asynchronously.
- FLASHRAM_STATUS_CLEAR_EN: after a job completes with status 0x8, write 0x0000 to 0x2 in STATUS mode -> status 0x0. With the macro undefined -> status stays 0x8.
